// File: rtl/carregador_so.sv
`default_nettype none
// ============================================================================
// Module   : carregador_so
// Purpose  : Boot-time OS copy engine. This block is the responder side of the
//            BIOS boot handshake. It answers the module-check request, then
//            copies the OS image word by word from the HD memory into
//            instruction memory.
// Ports    : clk, rst_n               clock and asynchronous active-low reset
//            sinal_teste / sinal_ok   BIOS module check and ready response
//            sinal_mux                boot-copy command strobe (rising edge)
//            instrucao_inicio         [31:27] opcode, [26:16] dst base,
//                                     [15:0] HD source address
//            trava_pc                 number of words to copy
//            hd_leitura/endereco/dado HD read port
//            mem_inst_escrita/endereco/dado  instruction-memory write port
//            ocupado, concluido, erro copy status
// Options  : OPCODE_CHECK_EN - when defined, commands whose opcode differs
//            from COPY_OPCODE are rejected with a one-cycle erro pulse.
// Revision : 1.0 - initial release
// ============================================================================
module carregador_so #(
  parameter int         HD_LATENCY  = 2,
  parameter logic [4:0] COPY_OPCODE = 5'b11111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sinal_teste,
  output logic        sinal_ok,
  input  logic        sinal_mux,
  input  logic [31:0] instrucao_inicio,
  input  logic [15:0] trava_pc,
  output logic        hd_leitura,
  output logic [15:0] hd_endereco,
  input  logic [31:0] hd_dado,
  output logic        mem_inst_escrita,
  output logic [15:0] mem_inst_endereco,
  output logic [31:0] mem_inst_dado,
  output logic        ocupado,
  output logic        concluido,
  output logic        erro
);

  localparam logic [2:0] OCIOSO   = 3'd0;
  localparam logic [2:0] LER      = 3'd1;
  localparam logic [2:0] ESPERA   = 3'd2;
  localparam logic [2:0] ESCREVER = 3'd3;
  localparam logic [2:0] FIM      = 3'd4;

  // Last ESPERA cycle: hd_dado is valid during it and is latched at its end.
  localparam logic [3:0] LAT_LAST = 4'(HD_LATENCY - 1);

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic        pronto;
  logic        mux_prev;
  logic [15:0] src;
  logic [15:0] dst;
  logic [15:0] n;
  logic [15:0] i;
  logic [15:0] i_inc;
  logic [15:0] rd_addr;
  logic [15:0] wr_addr;
  logic [15:0] hd_end_hold;
  logic [15:0] mem_end_hold;
  logic [31:0] dado;
  logic [3:0]  wait_cnt;
  logic        cmd_edge;
  logic        cmd_reject;
  logic        cmd_accept;

  // Only a fresh rising edge seen while idle counts as a command.
  assign cmd_edge   = sinal_mux & ~mux_prev & (state == OCIOSO);
  assign cmd_accept = cmd_edge & ~cmd_reject;

  assign i_inc   = i + 16'd1;
  assign rd_addr = src + i;
  assign wr_addr = dst + i;

`ifdef OPCODE_CHECK_EN
  logic erro_q;

  assign cmd_reject = cmd_edge & (instrucao_inicio[31:27] != COPY_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      erro_q <= 1'b0;
    end else begin
      erro_q <= cmd_reject;
    end
  end

  assign erro = erro_q;
`else
  logic unused_opcode;

  assign cmd_reject    = 1'b0;
  assign erro          = 1'b0;
  assign unused_opcode = &{1'b0, instrucao_inicio[31:27], COPY_OPCODE};
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OCIOSO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      OCIOSO: begin
        if (cmd_accept) begin
          state_next = (trava_pc != 16'd0) ? LER : FIM;
        end
      end
      LER: state_next = ESPERA;
      ESPERA: begin
        if (wait_cnt == LAT_LAST) begin
          state_next = ESCREVER;
        end
      end
      ESCREVER: state_next = (i_inc == n) ? FIM : LER;
      FIM: state_next = OCIOSO;
      default: state_next = OCIOSO;
    endcase
  end

  // Datapath: command latch, word index, latency counter, data and
  // address-hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pronto       <= 1'b0;
      mux_prev     <= 1'b0;
      src          <= 16'd0;
      dst          <= 16'd0;
      n            <= 16'd0;
      i            <= 16'd0;
      wait_cnt     <= 4'd0;
      dado         <= 32'd0;
      hd_end_hold  <= 16'd0;
      mem_end_hold <= 16'd0;
    end else begin
      pronto   <= 1'b1;
      mux_prev <= sinal_mux;
      case (state)
        OCIOSO: begin
          if (cmd_accept) begin
            src <= instrucao_inicio[15:0];
            dst <= {5'b0, instrucao_inicio[26:16]};
            n   <= trava_pc;
            i   <= 16'd0;
          end
        end
        LER: begin
          wait_cnt    <= 4'd0;
          hd_end_hold <= rd_addr;
        end
        ESPERA: begin
          if (wait_cnt == LAT_LAST) begin
            dado <= hd_dado;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ESCREVER: begin
          mem_end_hold <= wr_addr;
          i            <= i_inc;
        end
        default: begin
        end
      endcase
    end
  end

  // Output logic (addresses show the live value while strobed, else hold)
  always_comb begin
    hd_leitura        = (state == LER);
    hd_endereco       = (state == LER) ? rd_addr : hd_end_hold;
    mem_inst_escrita  = (state == ESCREVER);
    mem_inst_endereco = (state == ESCREVER) ? wr_addr : mem_end_hold;
    mem_inst_dado     = dado;
    ocupado           = (state != OCIOSO);
    concluido         = (state == FIM);
    sinal_ok          = sinal_teste & pronto & (state == OCIOSO);
  end

endmodule
`default_nettype wire

// File: doc/carregador_so.md
Name: carregador_so

Overview:
- Boot-time OS copy engine; the responder side of the BIOS boot handshake.
- Answers the BIOS module-check request with a ready indication.
- On the BIOS boot-copy command (sinal_mux pulse carrying instrucao_inicio, word count on trava_pc), reads the OS image word by word from the HD memory and writes it into instruction memory.
- Sits between the BIOS, the HD memory read port and the instruction memory write port.

Parameters:
- HD_LATENCY, 2, cycles from hd_leitura assertion to valid hd_dado (legal range 1..15).
- COPY_OPCODE, 5'b11111, opcode value accepted in instrucao_inicio[31:27] (used only with OPCODE_CHECK_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- sinal_teste  in  1  BIOS module-check request.
- sinal_ok  out  1  ready response to BIOS.
- sinal_mux  in  1  BIOS boot-copy command strobe.
- instrucao_inicio  in  32  command: [31:27] opcode, [26:16] destination base (11b), [15:0] HD source address.
- trava_pc  in  16  number of words to copy.
- hd_leitura  out  1  HD read strobe.
- hd_endereco  out  16  HD read address.
- hd_dado  in  32  HD read data.
- mem_inst_escrita  out  1  instruction-memory write enable.
- mem_inst_endereco  out  16  instruction-memory write address.
- mem_inst_dado  out  32  instruction-memory write data.
- ocupado  out  1  copy in progress.
- concluido  out  1  one-cycle completion pulse.
- erro  out  1  one-cycle command-rejected pulse.

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; state OCIOSO; internal pronto=0; counters, address and data registers 0.
  - Reset mid-copy aborts immediately: no further writes and no concluido.
- pronto is set on the first clk edge after rst_n rises.
- sinal_ok is combinational: sinal_teste & pronto & (state==OCIOSO). It is 0 while copying, so BIOS samples a failed module.
- Command capture:
  - A rising edge of sinal_mux (registered previous value vs current) in OCIOSO latches src=instrucao_inicio[15:0], dst={5'b0, instrucao_inicio[26:16]} and n=trava_pc.
  - A rising edge while not in OCIOSO is ignored: no latch, no erro.
  - A level held high does not retrigger.
- States:
  - OCIOSO: idle. On command go to LER if n!=0, else FIM.
  - LER (1 cycle): hd_leitura=1, hd_endereco=src+i. Then go to ESPERA.
  - ESPERA: counts HD_LATENCY-1 further cycles. On the cycle hd_dado is valid (HD_LATENCY edges after the LER edge), latch it. Then go to ESCREVER.
  - ESCREVER (1 cycle): mem_inst_escrita=1, mem_inst_endereco=dst+i, mem_inst_dado=latched word. Increment i; if i==n go to FIM, else LER.
  - FIM (1 cycle): concluido=1. Then go to OCIOSO.
- ocupado=1 in LER, ESPERA, ESCREVER and FIM.
- Per-word cost: HD_LATENCY+2 cycles. Total copy: n*(HD_LATENCY+2)+1 cycles from the command edge to the concluido cycle.
- Address arithmetic: 16-bit, wraps modulo 2^16 (src=16'hFFFF, i=1 → 16'h0000). i is 16-bit; n=16'hFFFF is legal.
- hd_endereco and mem_inst_endereco hold their last values when their strobes are low; their strobes are never high together.
- Input changes on trava_pc or instrucao_inicio during a copy have no effect.

Optional Feature:
- Macro OPCODE_CHECK_EN.
- Defined: on command capture, if instrucao_inicio[31:27]!=COPY_OPCODE, stay in OCIOSO, pulse erro for 1 cycle, perform no HD read; matching opcode proceeds normally.
- Undefined: opcode field ignored, erro tied to 0.

Test Plan:
- Reset then sinal_teste=1 → sinal_ok=1 from the second cycle after rst_n rise; during a copy sinal_ok=0.
- HD_LATENCY=2, instrucao_inicio={5'b11111, 11'd1, 16'h0020}, trava_pc=42, 1-cycle sinal_mux → 42 writes at mem addr 1..42 with data from HD 0x20..0x49; concluido exactly 169 cycles after the command edge.
- trava_pc=0 → no hd_leitura, no write; concluido pulses on the cycle after the command edge.
- src=16'hFFFE, trava_pc=3 → HD reads at FFFE, FFFF, 0000.
- rst_n low during ESPERA of word 5 → outputs 0 asynchronously; no concluido; new command after reset copies normally. Second sinal_mux edge mid-copy is ignored.
- OPCODE_CHECK_EN defined, opcode 5'b00000 → erro 1-cycle pulse, ocupado stays 0, no HD read.
